// File: rtl/counter_seq_ctrl_if.sv
// Control/status and counter-feedback bundle between the register logic,
// the counter_up_8bit datapath and counter_seq_ctrl.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             mode;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] q_in;
    logic             cnt_reset;
    logic             cnt_ce;
    logic             cnt_en;
    logic             done;
    logic             busy;
    logic [2:0]       state;

    modport master (
        output start, stop, mode, period, q_in,
        input  cnt_reset, cnt_ce, cnt_en, done, busy, state
    );

    modport slave (
        input  start, stop, mode, period, q_in,
        output cnt_reset, cnt_ce, cnt_en, done, busy, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for one counter_up_8bit: prescaled count to a latched
// terminal value, one-shot/periodic, pause/resume. Optional sticky irq via COUNTER_SEQ_CTRL_IRQ_EN.
module counter_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int CE_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    counter_seq_ctrl_if.slave  bus
`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    ,
    input  logic               irq_clr,
    output logic               irq
`endif
);

    localparam int PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CE_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             terminal;

    assign terminal = (bus.q_in == period_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // stop outranks start everywhere; terminal count outranks stop in RUN
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        period_d = period_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = CLEAR;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                end
            end
            CLEAR: begin
                pre_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
                if (terminal) begin
                    done_d  = 1'b1;
                    state_d = mode_q ? CLEAR : DONE;
                end else if (bus.stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d  = CLEAR;
                    period_d = bus.period;
                    mode_d   = bus.mode;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cnt_reset = (state_q == CLEAR);
    assign bus.cnt_en    = (state_q == RUN);
    assign bus.cnt_ce    = (state_q == RUN) && (pre_q == PRE_MAX) && !terminal;
    assign bus.busy      = (state_q == CLEAR) || (state_q == RUN) || (state_q == PAUSE);
    assign bus.state     = state_q;
    assign bus.done      = done_q;

`ifdef COUNTER_SEQ_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Set rises together with the done pulse and beats a simultaneous clear
    always_comb begin
        irq_d = irq_q;
        if (done_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule
